// File: rtl/core_control.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback with a memory wait timeout.
// Strobes decode from the current state plus same-cycle mem_ready/branch_taken; rst forces them low at once.
module core_control #(
  parameter int MaxWait = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        halted,
  output logic        illegal,
  output logic        bus_error,
  output logic [2:0]  state
);
  localparam int CW = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MaxWait);

  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_ARITHR = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_illegal;
  logic            r_bus_error;

  logic [6:0]      w_op;
  logic            w_legal;
  logic [1:0]      w_a_sel;
  logic            w_b_sel;
  logic            w_timeout;
  logic            w_unused;

  assign w_op      = instr[6:0];
  assign w_unused  = ^instr[31:12];
  assign w_timeout = (MaxWait > 0) && (r_cnt == MAX_CNT) && !mem_ready;

  always_comb begin
    w_legal = 1'b1;
    w_a_sel = 2'd0;
    w_b_sel = 1'b0;
    case (w_op)
      OP_ARITHR, OP_SYSTEM: w_b_sel = 1'b0;
      OP_ARITHI, OP_LOAD, OP_STORE, OP_JALR: w_b_sel = 1'b1;
      OP_LUI: begin
        w_a_sel = 2'd2;
        w_b_sel = 1'b1;
      end
      OP_AUIPC, OP_JAL, OP_BRANCH: begin
        w_a_sel = 2'd1;
        w_b_sel = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Wait counter only ever moves in FETCH/MEMORY; every transition below clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_cnt       <= '0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH, S_MEMORY: begin
          if (mem_ready) begin
            r_cnt <= '0;
            if (r_state == S_FETCH)  r_state <= S_DECODE;
            else if (w_op == OP_STORE) r_state <= S_FETCH;
            else                     r_state <= S_WRITEBACK;
          end else if (w_timeout) begin
            r_cnt       <= '0;
            r_state     <= S_HALT;
            r_bus_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          r_cnt <= '0;
          if (!w_legal) begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end else if (w_op == OP_SYSTEM) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          r_cnt <= '0;
          if (w_op == OP_BRANCH)                         r_state <= S_FETCH;
          else if (w_op == OP_LOAD || w_op == OP_STORE)  r_state <= S_MEMORY;
          else                                           r_state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          r_cnt   <= '0;
          r_state <= S_FETCH;
        end
        S_HALT: r_cnt <= '0;
        default: begin
          r_cnt   <= '0;
          r_state <= S_HALT;
        end
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    retire       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_EXECUTE: begin
          alu_a_sel = w_a_sel;
          alu_b_sel = w_b_sel;
          if (w_op == OP_BRANCH) begin
            pc_we  = 1'b1;
            pc_sel = branch_taken ? 2'd1 : 2'd0;
            retire = 1'b1;
          end
        end
        S_MEMORY: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (w_op == OP_STORE);
          alu_a_sel    = w_a_sel;
          alu_b_sel    = w_b_sel;
          if (mem_ready && w_op == OP_STORE) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        S_WRITEBACK: begin
          alu_a_sel = w_a_sel;
          alu_b_sel = w_b_sel;
          rf_we     = |instr[11:7];
          pc_we     = 1'b1;
          retire    = 1'b1;
          if (w_op == OP_LOAD)                        wb_sel = 2'd1;
          else if (w_op == OP_JAL || w_op == OP_JALR) wb_sel = 2'd2;
          if (w_op == OP_JAL)       pc_sel = 2'd1;
          else if (w_op == OP_JALR) pc_sel = 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign halted    = (r_state == S_HALT);
  assign illegal   = r_illegal;
  assign bus_error = r_bus_error;
  assign state     = r_state;

endmodule

// File: doc/core_control.md
CORE_CONTROL -- requirements
Module: core_control

Interface
REQ-001 SHALL have parameter MaxWait, default 255: the memory wait-cycle limit. A value of 0 disables the timeout.
REQ-002 SHALL have ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr  in  32  instruction-register contents, stable except after ir_we.
- mem_ready  in  1  memory completion strobe.
- branch_taken  in  1  external comparator result for the current Branch.
- mem_req  out  1  memory request.
- mem_we  out  1  store (1) or read (0).
- mem_addr_sel  out  1  address source: 0 = PC, 1 = ALU result.
- ir_we  out  1  capture the fetched word into the instruction register.
- pc_we  out  1  PC update.
- pc_sel  out  2  next PC: 0 = pc+4, 1 = ALU result, 2 = ALU result with bit0 cleared.
- alu_a_sel  out  2  ALU A operand: 0 = rs1, 1 = pc, 2 = zero.
- alu_b_sel  out  1  ALU B operand: 0 = rs2, 1 = immediate.
- rf_we  out  1  register-file write.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = load data, 2 = pc+4.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped.
- illegal  out  1  sticky: halt caused by an illegal instruction.
- bus_error  out  1  sticky: halt caused by a memory timeout.
- state  out  3  current state encoding.

Function
REQ-003 SHALL implement the states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5. Encodings 6-7 are unreachable; if entered, the next state SHALL be HALT.
REQ-004 Opcode is instr[6:0]. Legal opcodes: AuiPc 0010111, ArithI 0010011, ArithR 0110011, Branch 1100011, Jal 1101111, Jalr 1100111, Load 0000011, Lui 0110111, Store 0100011, System 1110011.
REQ-005 All outputs not asserted by the rules below SHALL be 0.
REQ-006 FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. When mem_ready=1: ir_we=1 in that same cycle, and the next state is DECODE.
REQ-007 DECODE: no strobes.
- Opcode not legal -> HALT, and illegal is set.
- System -> HALT, illegal stays 0.
- Any other opcode -> EXECUTE.
REQ-008 EXECUTE, operand selects per opcode:
- ArithR: a=0, b=0.
- ArithI, Load, Store, Jalr: a=0, b=1.
- Lui: a=2, b=1.
- AuiPc, Jal, Branch: a=1, b=1.
REQ-009 EXECUTE, Branch: pc_we=1, pc_sel=1 if branch_taken, else 0; retire=1; next state FETCH.
REQ-010 EXECUTE, Load/Store: next state MEMORY. All other opcodes: next state WRITEBACK.
REQ-011 MEMORY: mem_req=1, mem_addr_sel=1, alu selects held as in EXECUTE, mem_we=1 only for Store. When mem_ready=1:
- Store: pc_we=1, pc_sel=0, retire=1, next state FETCH.
- Load: next state WRITEBACK.
REQ-012 WRITEBACK:
- rf_we=1 unless instr[11:7]==0.
- wb_sel: Load=1; Jal/Jalr=2; otherwise 0.
- pc_we=1; pc_sel: Jal=1, Jalr=2, otherwise 0.
- ALU selects held as in EXECUTE.
- retire=1; next state FETCH.
REQ-013 Wait counter:
- Width is clog2(MaxWait+1), minimum 1.
- Increments each FETCH/MEMORY cycle with mem_ready=0.
- Clears on every state change.
- If MaxWait>0 and the counter equals MaxWait while mem_ready=0, the next state is HALT and bus_error is set.
- mem_ready arriving in that same cycle wins: normal transition, no error.
REQ-014 HALT: halted=1 and all strobes 0. It is exited only by rst; mem_ready and instr are ignored.
REQ-015 Zero-wait latency, in cycles:
- ArithR, ArithI, Lui, AuiPc, Jal, Jalr: 4.
- Branch: 3.
- Store: 4.
- Load: 5.
REQ-016 At most one retire pulse per instruction; none for instructions that halt.

Reset
REQ-017 While rst=1: state=FETCH; wait counter=0; illegal=0, bus_error=0, halted=0; every strobe output (mem_req, ir_we, pc_we, rf_we, retire, mem_we) forced to 0.
REQ-018 Reset asserted mid-operation (any state, including HALT or a pending MEMORY request) SHALL abandon the instruction with no further strobes. The first cycle after deassertion is FETCH with mem_req=1.

Verification
REQ-019 ADDI x1 (0x00100093), mem_ready=1 every cycle -> states 0,1,2,4,0. ir_we in cycle 0; rf_we=1, wb_sel=0, pc_sel=0, retire=1 in cycle 3.
REQ-020 LW x2 (0x0000A103), MEMORY ready after 3 wait cycles -> mem_req=1, mem_addr_sel=1 held 4 cycles. Then WRITEBACK with wb_sel=1, rf_we=1; total 8 cycles.
REQ-021 BEQ (0x00000063) with branch_taken=1 -> EXECUTE drives pc_we=1, pc_sel=1, retire=1, then FETCH. With branch_taken=0 -> pc_sel=0.
REQ-022 instr=0xFFFFFFFF -> DECODE goes to HALT; illegal=1, halted=1, no retire. ECALL 0x00000073 -> HALT with illegal=0.
REQ-023 MaxWait=4, mem_ready never asserted in FETCH -> HALT entered after 5 FETCH cycles, bus_error=1. With mem_ready on the 5th cycle -> DECODE, no error.
REQ-024 rst pulsed during MEMORY of a Store -> mem_we/mem_req drop asynchronously; after release the state is FETCH, and halted, illegal and bus_error are all 0.
